// File: rtl/mat_key_scanner_pkg.sv
// Shared types and sizing helpers for the matrix keypad scanner.
package mat_key_pkg;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int MAX_CODE_W = 6;  // 8x8 matrix upper bound

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int code_w(input int rows, input int cols);
    return clog2(rows * cols);
  endfunction

  typedef struct packed {
    logic                  is_release;
    logic [MAX_CODE_W-1:0] code;
  } key_evt_t;
endpackage

// File: rtl/mat_key_scanner_if.sv
// Press/release event stream from the scanner to its consumer.
interface mat_key_scanner_if #(parameter int CODE_W = 4);
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_release;
  logic              evt_ready;

  modport master (output evt_valid, evt_code, evt_release, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_release, output evt_ready);
endinterface

// File: rtl/mat_key_scanner_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is taken only with a same-cycle pop.
module key_evt_fifo
  import mat_key_pkg::*;
#(
  parameter int W     = 7,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          pop_ok, push_ok;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rp];

  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mat_key_scanner.sv
// Matrix keypad scanner: one-cold row strobes, per-key debounce, press/release event FIFO.
module mat_key_scanner
  import mat_key_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int SCAN_DIV       = 1024,
  parameter int DB_LEN         = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int COL_ACTIVE_LOW = 1,
  localparam int NK            = ROWS * COLS,
  localparam int CODE_W        = code_w(ROWS, COLS),
  localparam int FW            = clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_drive,
  output logic [NK-1:0]   key_state,
  output logic            frame_done,
  output logic [FW:0]     evt_count,
  output logic            overflow,
  mat_key_scanner_if.master evt
);
  localparam int DW = clog2(SCAN_DIV);
  localparam int RW = clog2(ROWS);

  logic [DW-1:0]                   div_cnt;
  logic [RW-1:0]                   row_idx, drain_row;
  // Only the DB_LEN-1 newest samples are kept; with the incoming sample they form the DB_LEN window.
  logic [NK-1:0][DB_LEN-2:0]       hist;
  logic [COLS-1:0][DB_LEN-1:0]     nh;
  logic [COLS-1:0]                 samp, row_old, row_new, pending, low_bit;
  logic                            tick, push, pop, full, empty, unused_code_hi;
  key_evt_t                        push_evt, head;
  int                              dc, dk;

  assign tick       = div_cnt == DW'(SCAN_DIV - 1);
  assign frame_done = tick & (row_idx == RW'(ROWS - 1));
  assign row_drive  = ~(ROWS'(1) << row_idx);
  assign samp       = col_in ^ {COLS{1'(COL_ACTIVE_LOW)}};

  always_comb begin
    nh      = '0;
    row_old = '0;
    row_new = '0;
    for (int c = 0; c < COLS; c++) begin
      nh[c]      = {hist[int'(row_idx)*COLS + c], samp[c]};
      row_old[c] = key_state[int'(row_idx)*COLS + c];
      row_new[c] = (&nh[c]) ? 1'b1 : ((|nh[c]) ? row_old[c] : 1'b0);
    end
  end

  // Drain the lowest pending column first, one event per cycle.
  always_comb begin
    dc = 0;
    for (int c = COLS - 1; c >= 0; c--)
      if (pending[c]) dc = c;
    dk                  = int'(drain_row) * COLS + dc;
    low_bit             = pending & (~pending + COLS'(1));
    push                = |pending;
    push_evt.code       = MAX_CODE_W'(dk);
    push_evt.is_release = ~key_state[dk];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      row_idx   <= '0;
      drain_row <= '0;
      hist      <= '0;
      key_state <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        row_idx   <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
        drain_row <= row_idx;
        pending   <= row_new ^ row_old;
        for (int c = 0; c < COLS; c++) begin
          hist[int'(row_idx)*COLS + c]      <= nh[c][DB_LEN-2:0];
          key_state[int'(row_idx)*COLS + c] <= row_new[c];
        end
      end else begin
        pending <= pending & ~low_bit;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign pop = ~empty & evt.evt_ready;

  key_evt_fifo #(.W($bits(key_evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head),
    .count (evt_count),
    .full  (full),
    .empty (empty)
  );

  assign evt.evt_valid   = ~empty;
  assign evt.evt_code    = head.code[CODE_W-1:0];
  assign evt.evt_release = head.is_release;
  assign unused_code_hi  = ^head.code;
endmodule
